// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings for the ALU and branch comparator.
// The EX control decoder uses the same constants.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SLL    = 4'b0001;
  localparam logic [3:0] ALU_SLT    = 4'b0010;
  localparam logic [3:0] ALU_SLTU   = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SRL    = 4'b0101;
  localparam logic [3:0] ALU_OR     = 4'b0110;
  localparam logic [3:0] ALU_AND    = 4'b0111;
  localparam logic [3:0] ALU_SUB    = 4'b1000;
  localparam logic [3:0] ALU_PASS_B = 4'b1001;
  localparam logic [3:0] ALU_JALR   = 4'b1010;
  localparam logic [3:0] ALU_SRA    = 4'b1101;

  localparam logic [2:0] BR_EQ     = 3'b000;
  localparam logic [2:0] BR_NE     = 3'b001;
  localparam logic [2:0] BR_ALWAYS = 3'b010;
  localparam logic [2:0] BR_NEVER  = 3'b011;
  localparam logic [2:0] BR_LT     = 3'b100;
  localparam logic [2:0] BR_GE     = 3'b101;
  localparam logic [2:0] BR_LTU    = 3'b110;
  localparam logic [2:0] BR_GEU    = 3'b111;

endpackage

// File: rtl/ex_alu.sv
// Combinational RV32I ALU; undefined opcodes produce zero.
module ex_alu
  import rv32i_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_op,
  output logic [XLEN-1:0] y
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] sum;

  assign shamt = b[4:0];
  assign sum   = a + b;

  always_comb begin
    y = '0;
    unique case (alu_op)
      ALU_ADD:    y = sum;
      ALU_SUB:    y = a - b;
      ALU_SLL:    y = a << shamt;
      ALU_SLT:    y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:   y = {31'b0, a < b};
      ALU_XOR:    y = a ^ b;
      ALU_SRL:    y = a >> shamt;
      ALU_SRA:    y = $unsigned($signed(a) >>> shamt);
      ALU_OR:     y = a | b;
      ALU_AND:    y = a & b;
      ALU_PASS_B: y = b;
      ALU_JALR:   y = {sum[XLEN-1:1], 1'b0};
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand muxes, ALU, branch resolution and the EX/MEM register.
// The branch/jump target is the ALU result, so redirect_pc aliases alu_result.
module ex_stage
  import rv32i_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic             a_sel,
  input  logic             b_sel,
  input  logic [3:0]       alu_op,
  input  logic [2:0]       branch_alu_op,
  input  logic [4:0]       rd_in,
  output logic             out_valid,
  output logic [XLEN-1:0]  alu_result,
  output logic [XLEN-1:0]  store_data,
  output logic [4:0]       rd_out,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             misaligned
);

  logic [XLEN-1:0] op_a, op_b, alu_y;
  logic            taken;
  logic            redirect_d;

  logic            valid_q, redirect_q, misaligned_q;
  logic [XLEN-1:0] alu_q, store_q, pc4_q;
  logic [4:0]      rd_q;

  assign op_a = a_sel ? pc  : rs1_data;
  assign op_b = b_sel ? imm : rs2_data;

  ex_alu u_alu (
    .a      (op_a),
    .b      (op_b),
    .alu_op (alu_op),
    .y      (alu_y)
  );

  // Conditions always compare the register sources, whatever the operand muxes select.
  always_comb begin
    taken = 1'b0;
    unique case (branch_alu_op)
      BR_EQ:     taken = (rs1_data == rs2_data);
      BR_NE:     taken = (rs1_data != rs2_data);
      BR_LT:     taken = ($signed(rs1_data) <  $signed(rs2_data));
      BR_GE:     taken = ($signed(rs1_data) >= $signed(rs2_data));
      BR_LTU:    taken = (rs1_data <  rs2_data);
      BR_GEU:    taken = (rs1_data >= rs2_data);
      BR_ALWAYS: taken = 1'b1;
      BR_NEVER:  taken = 1'b0;
      default:   taken = 1'b0;
    endcase
  end

  assign redirect_d = in_valid & taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      redirect_q   <= 1'b0;
      misaligned_q <= 1'b0;
      alu_q        <= '0;
      store_q      <= '0;
      pc4_q        <= '0;
      rd_q         <= '0;
    end else if (flush) begin
      // Data registers are don't-care after a flush; only the flags are cleared.
      valid_q      <= 1'b0;
      redirect_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else if (!stall) begin
      valid_q      <= in_valid;
      redirect_q   <= redirect_d;
      misaligned_q <= redirect_d & (alu_y[1:0] != 2'b00);
      alu_q        <= alu_y;
      store_q      <= rs2_data;
      pc4_q        <= pc + 32'd4;
      rd_q         <= rd_in;
    end
  end

  assign out_valid   = valid_q;
  assign redirect    = redirect_q;
  assign misaligned  = misaligned_q;
  assign alu_result  = alu_q;
  assign redirect_pc = alu_q;
  assign store_data  = store_q;
  assign pc_plus4    = pc4_q;
  assign rd_out      = rd_q;

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: in_valid  input  1  decode-stage instruction valid this cycle.
REQ-004 SHALL have port: stall  input  1  hold EX/MEM register contents.
REQ-005 SHALL have port: flush  input  1  squash the instruction being latched.
REQ-006 SHALL have port: pc  input  32  instruction address.
REQ-007 SHALL have port: rs1_data  input  32  register source 1.
REQ-008 SHALL have port: rs2_data  input  32  register source 2.
REQ-009 SHALL have port: imm  input  32  sign-extended immediate.
REQ-010 SHALL have port: a_sel  input  1  0 selects rs1_data, 1 selects pc, for ALU operand A.
REQ-011 SHALL have port: b_sel  input  1  0 selects rs2_data, 1 selects imm, for ALU operand B.
REQ-012 SHALL have port: alu_op  input  4  ALU operation code.
REQ-013 SHALL have port: branch_alu_op  input  3  branch condition code.
REQ-014 SHALL have port: rd_in  input  5  destination register index.
REQ-015 SHALL have port: out_valid  output  1  EX/MEM entry valid.
REQ-016 SHALL have port: alu_result  output  32  registered ALU result.
REQ-017 SHALL have port: store_data  output  32  registered rs2_data.
REQ-018 SHALL have port: rd_out  output  5  registered rd_in.
REQ-019 SHALL have port: pc_plus4  output  32  registered pc+4, the link value.
REQ-020 SHALL have port: redirect  output  1  registered taken branch or jump.
REQ-021 SHALL have port: redirect_pc  output  32  target address; meaningful only when redirect=1.
REQ-022 SHALL have port: misaligned  output  1  registered flag: taken target with nonzero bits [1:0].

Function
REQ-023 SHALL implement alu_op encodings: 0000 ADD; 1000 SUB; 0001 SLL; 0010 SLT (signed); 0011 SLTU; 0100 XOR; 0101 SRL; 1101 SRA; 0110 OR; 0111 AND; 1001 pass B; 1010 (A+B) with bit0 cleared; any other code SHALL yield 0.
REQ-024 SHALL use only B[4:0] as the shift amount; SLT and SLTU SHALL produce 32'd1 or 32'd0; all arithmetic SHALL be modulo 2^32.
REQ-025 SHALL implement branch_alu_op encodings: 000 EQ; 001 NE; 100 LT (signed); 101 GE (signed); 110 LTU; 111 GEU; 010 always taken; 011 never taken; 01x codes outside these SHALL be treated as never taken. Comparisons SHALL always use rs1_data versus rs2_data, independent of a_sel and b_sel.
REQ-026 SHALL have a latency of 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
REQ-027 SHALL have the target equal to the ALU result, and redirect_pc SHALL be the registered alu_result.
REQ-028 SHALL, when the captured instruction is valid and taken, set redirect=1; misaligned SHALL equal redirect AND (target[1:0]!=0).
REQ-029 SHALL give priority at each edge as flush > stall > load: flush clears out_valid, redirect and misaligned, with data registers don't-care; stall holds every register; otherwise all registers load.
REQ-030 SHALL, when in_valid=0 and the register loads, latch out_valid=0, redirect=0 and misaligned=0.
REQ-031 SHALL have redirect and misaligned never asserted while out_valid=0.
REQ-032 SHALL assert redirect for exactly one cycle per taken instruction unless stall holds it; a held redirect SHALL stay asserted.

Reset
REQ-033 SHALL asynchronously clear out_valid, redirect and misaligned to 0 when rst=1.
REQ-034 SHALL asynchronously clear alu_result, store_data, redirect_pc and pc_plus4 to 32'h0 and rd_out to 5'h0 when rst=1.
REQ-035 SHALL, when reset asserts mid-stall, leave no state surviving, and the first edge after deassertion SHALL obey REQ-029.

Structure
REQ-036 SHALL define the alu_op and branch_alu_op encodings as named constants in shared package rv32i_pkg, which is also used by the EX control decoder.
REQ-037 SHALL place the combinational ALU in sub-module ex_alu (inputs a, b, alu_op; output y); the branch comparator, operand muxes and EX/MEM register SHALL reside in ex_stage.

Verification
REQ-038 SHALL cover: SUB with rs1=5, rs2=7, a_sel=0, b_sel=0 -> alu_result=32'hFFFFFFFE, out_valid=1 one cycle later.
REQ-039 SHALL cover: SRA with rs1=32'h80000000, imm=32'h404 (shamt 4), b_sel=1 -> 32'hF8000000; SRL with the same operands -> 32'h08000000.
REQ-040 SHALL cover: BLT with rs1=32'hFFFFFFFF, rs2=1, pc=32'h100, imm=8, a_sel=1, b_sel=1 -> redirect=1, redirect_pc=32'h108; BLTU with the same operands -> redirect=0.
REQ-041 SHALL cover: JALR with rs1=32'h203, imm=0, alu_op 1010, branch 010 -> redirect_pc=32'h202, misaligned=1, pc_plus4=pc+4.
REQ-042 SHALL cover: taken BEQ latched, then stall=1 for 3 cycles -> all outputs held with redirect=1 throughout; flush and stall both high -> out_valid=0 and redirect=0 next cycle.
REQ-043 SHALL cover: rst pulsed asynchronously between edges while out_valid=1 -> all outputs become 0 immediately, without a clock edge.
